// File: rtl/ot_pkg.sv
// Shared definitions for the oblivious-transfer sender/receiver byte link.
package ot_pkg;

  localparam int unsigned BITS_PER_BYTE = 8;

  // Header value shared by the tx serializer and the rx deserializer.
  localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StDone = 2'd2
  } ot_state_e;

  // Bytes carried by one packed word of the given bit width.
  function automatic int unsigned bytes_per_word(input int unsigned width);
    return width / BITS_PER_BYTE;
  endfunction

endpackage

// File: rtl/ot_tx_serializer.sv
// Captures two packed ciphertext words on load and streams them as bytes
// over a valid/ready channel, optionally preceded by a header byte.
module ot_tx_serializer
  import ot_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned HEADER_EN   = 0,
  parameter logic [7:0]  HEADER_BYTE = HEADER_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] packed_data0,
  input  logic [DATA_W-1:0] packed_data1,
  output logic              busy,
  output logic              done,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [7:0]        tx_data
);

  localparam int unsigned NB    = bytes_per_word(DATA_W);
  localparam int unsigned TOTAL = 2 * NB + HEADER_EN;
  localparam int unsigned CW    = $clog2(TOTAL + 1);
  localparam int unsigned SW    = 2 * DATA_W;
  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

  ot_state_e       state_q;
  logic [CW-1:0]   cnt_q;
  logic [SW-1:0]   shreg_q;
  logic            hdr_slot;

  // Header occupies slot 0; the payload must not shift while it is on the wire.
  assign hdr_slot = (HEADER_EN != 0) && (cnt_q == '0);

  // Transfer FSM; tx_data always holds the byte for the current slot, so the
  // following byte is preloaded on each handshake to sustain one byte/cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      shreg_q  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (load) begin
            shreg_q  <= {packed_data0, packed_data1};
            cnt_q    <= '0;
            busy     <= 1'b1;
            tx_valid <= 1'b1;
            tx_data  <= (HEADER_EN != 0) ? HEADER_BYTE : packed_data0[DATA_W-1 -: 8];
            state_q  <= StSend;
          end
        end
        StSend: begin
          if (tx_ready) begin
            if (cnt_q == LAST) begin
              tx_valid <= 1'b0;
              tx_data  <= 8'h00;
              busy     <= 1'b0;
              done     <= 1'b1;
              cnt_q    <= '0;
              state_q  <= StDone;
            end else begin
              cnt_q <= cnt_q + 1'b1;
              if (hdr_slot) begin
                tx_data <= shreg_q[SW-1 -: 8];
              end else begin
                shreg_q <= shreg_q << 8;
                tx_data <= shreg_q[SW-9 -: 8];
              end
            end
          end
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q  <= StIdle;
          cnt_q    <= '0;
          busy     <= 1'b0;
          done     <= 1'b0;
          tx_valid <= 1'b0;
          tx_data  <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ot_tx_serializer.sv
// Directed bench for ot_tx_serializer: one instance without header, one with.
module tb_ot_tx_serializer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  load = 2'b00;
  logic [1:0]  ready = 2'b00;
  logic [31:0] pd0 = '0;
  logic [31:0] pd1 = '0;
  logic [1:0]  busy, done, valid;
  logic [7:0]  data0, data1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ot_tx_serializer #(.DATA_W(32), .HEADER_EN(0), .HEADER_BYTE(8'hA5)) dut0 (
    .clk(clk), .reset(reset), .load(load[0]), .packed_data0(pd0), .packed_data1(pd1),
    .busy(busy[0]), .done(done[0]), .tx_valid(valid[0]), .tx_ready(ready[0]), .tx_data(data0)
  );

  ot_tx_serializer #(.DATA_W(32), .HEADER_EN(1), .HEADER_BYTE(8'hA5)) dut1 (
    .clk(clk), .reset(reset), .load(load[1]), .packed_data0(pd0), .packed_data1(pd1),
    .busy(busy[1]), .done(done[1]), .tx_valid(valid[1]), .tx_ready(ready[1]), .tx_data(data1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] dat(input int s);
    return (s == 0) ? data0 : data1;
  endfunction

  // One full transfer on instance s. rmode 0: ready always high; rmode 1: ready
  // follows 1,0,0,1. spur issues an extra load (other data) mid-transfer.
  task automatic xfer(input int s, input logic [31:0] w0, input logic [31:0] w1,
                      input int rmode, input bit spur);
    logic [7:0] exp_b [9];
    int         n;
    int         idx;
    int         cyc;
    bit         prev_stall;
    logic [7:0] prev_data;
    bit         rpat [4];
    rpat = '{1'b1, 1'b0, 1'b0, 1'b1};
    n = (s == 0) ? 8 : 9;
    for (int i = 0; i < 4; i++) begin
      exp_b[i + n - 8]     = w0[31 - 8*i -: 8];
      exp_b[i + n - 4]     = w1[31 - 8*i -: 8];
    end
    if (s == 1) exp_b[0] = 8'hA5;

    load[s] = 1'b1;
    pd0 = w0;
    pd1 = w1;
    tick();
    load[s] = 1'b0;
    // Later input changes must not reach the stream.
    pd0 = 32'hDEADBEEF;
    pd1 = 32'h0BADF00D;
    check("first_valid", {31'b0, valid[s]}, 32'd1);
    check("first_busy", {31'b0, busy[s]}, 32'd1);

    idx = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_data = 8'h00;
    while (idx < n && cyc < 100) begin
      ready[s] = (rmode == 0) ? 1'b1 : rpat[cyc % 4];
      load[s]  = spur && (cyc == 2);
      if (prev_stall) check("hold", {24'b0, dat(s)}, {24'b0, prev_data});
      check("no_early_done", {31'b0, done[s]}, 32'd0);
      if (valid[s] && ready[s]) begin
        check("byte", {24'b0, dat(s)}, {24'b0, exp_b[idx]});
        idx++;
      end
      prev_stall = valid[s] && !ready[s];
      prev_data  = dat(s);
      tick();
      cyc++;
    end
    load[s]  = 1'b0;
    ready[s] = 1'b0;
    check("all_bytes", idx, n);
    if (rmode == 0) check("latency", cyc, n);
    check("done_pulse", {31'b0, done[s]}, 32'd1);
    check("end_valid", {31'b0, valid[s]}, 32'd0);
    check("end_busy", {31'b0, busy[s]}, 32'd0);
    check("end_data", {24'b0, dat(s)}, 32'd0);
    tick();
    check("done_one_cycle", {31'b0, done[s]}, 32'd0);
    check("idle_valid", {31'b0, valid[s]}, 32'd0);
  endtask

  initial begin
    tick();
    tick();
    check("rst_valid0", {31'b0, valid[0]}, 32'd0);
    check("rst_busy0", {31'b0, busy[0]}, 32'd0);
    check("rst_done0", {31'b0, done[0]}, 32'd0);
    check("rst_data0", {24'b0, data0}, 32'd0);
    check("rst_valid1", {31'b0, valid[1]}, 32'd0);
    check("rst_data1", {24'b0, data1}, 32'd0);
    reset = 1'b0;
    tick();

    // Basic, backpressure, header, header with backpressure, ignored load.
    xfer(0, 32'h11223344, 32'hAABBCCDD, 0, 1'b0);
    xfer(0, 32'h11223344, 32'hAABBCCDD, 1, 1'b0);
    xfer(1, 32'h11223344, 32'hAABBCCDD, 0, 1'b0);
    xfer(1, 32'h11223344, 32'hAABBCCDD, 1, 1'b0);
    xfer(0, 32'h11223344, 32'hAABBCCDD, 0, 1'b1);

    // Back-to-back: next load on the cycle right after the done pulse.
    xfer(0, 32'h11223344, 32'hAABBCCDD, 0, 1'b0);
    xfer(0, 32'h01020304, 32'h05060708, 0, 1'b0);

    // Reset after three handshakes must clear outputs without a clock edge.
    load[0]  = 1'b1;
    ready[0] = 1'b1;
    pd0 = 32'h11223344;
    pd1 = 32'hAABBCCDD;
    tick();
    load[0] = 1'b0;
    tick();
    tick();
    tick();
    check("pre_rst_data", {24'b0, data0}, 32'h44);
    #1 reset = 1'b1;
    #1;
    check("async_valid", {31'b0, valid[0]}, 32'd0);
    check("async_busy", {31'b0, busy[0]}, 32'd0);
    check("async_done", {31'b0, done[0]}, 32'd0);
    check("async_data", {24'b0, data0}, 32'd0);
    ready[0] = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    xfer(0, 32'h11223344, 32'hAABBCCDD, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
